// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles everything the Mini-SRC control unit exchanges with the datapath
//   and the RAM.
//   - Inputs to the sequencer: IR, Mem_done, Stop.
//   - Outputs from the sequencer: all bus/register/ALU/RAM strobes, the GPR
//     select vectors Rin/Rout, Run and Fault, and a debug copy of the FSM
//     state.
//   Memory handshake: the sequencer raises RAMRead or RAMWrite (the request,
//   "valid") and holds it unchanged until it samples Mem_done=1 (the
//   completion, "ready") in a memory-wait state.  The transfer completes on
//   that cycle.  Mem_done outside a wait state carries no meaning.
//   Modports:
//   - master: the sequencer.
//   - slave:  the datapath/RAM side (or a bench).
interface control_sequencer_if;
  logic [31:0] IR;
  logic        Mem_done;
  logic        Stop;

  logic PCout, Zlowout, Zhighout, MDRout, LOout, HIout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin;
  logic IncPC, Read, RAMRead, RAMWrite;
  logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        Run;
  logic        Fault;
  logic [3:0]  state_dbg;

  modport master (
    input  IR, Mem_done, Stop,
    output PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin,
    output IncPC, Read, RAMRead, RAMWrite,
    output ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
    output Rin, Rout, Run, Fault, state_dbg
  );

  modport slave (
    output IR, Mem_done, Stop,
    input  PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin,
    input  IncPC, Read, RAMRead, RAMWrite,
    input  ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV,
    input  Rin, Rout, Run, Fault, state_dbg
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Mini-SRC control unit (Moore FSM).
//   - Fetches an instruction from RAM, then executes one of: R-format ALU
//     ops, neg/not, mul/div, register-indirect ld/st, or halt.
//   - Strobes are decoded from the state register plus the IR fields.  The
//     only exception is Read/MDRin in a read-wait state, which follow
//     Mem_done.
//   Ports:
//   - Clock: rising-edge clock.
//   - Clear: asynchronous, active-low reset.  It forces every output to 0
//     while low.
//   - bus (master): IR/Mem_done/Stop in; all strobes, Rin/Rout, Run, Fault
//     and state_dbg out.
//   Parameter:
//   - MEM_WAIT_MAX: maximum number of cycles spent in one memory-wait
//     state.  0 means unlimited.  When the limit is hit, the sequencer sets
//     a sticky Fault and halts.
module control_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master bus
);

  localparam logic [3:0] S_FETCH0 = 4'd0;
  localparam logic [3:0] S_FETCH1 = 4'd1;
  localparam logic [3:0] S_FETCH2 = 4'd2;
  localparam logic [3:0] S_FETCH3 = 4'd3;
  localparam logic [3:0] S_DECODE = 4'd4;
  localparam logic [3:0] S_E0     = 4'd5;
  localparam logic [3:0] S_E1     = 4'd6;
  localparam logic [3:0] S_E2     = 4'd7;
  localparam logic [3:0] S_E3     = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic        WAIT_EN   = (MEM_WAIT_MAX != 0);
  // Count value seen on the last permitted wait cycle.  Meaningful only
  // when WAIT_EN is set.
  localparam logic [31:0] WAIT_LAST = 32'(MEM_WAIT_MAX) - 32'd1;

  logic [3:0]  state, state_nx;
  logic [31:0] wait_cnt;
  logic        fault;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       ir_unused;

  assign opcode    = bus.IR[31:27];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign ir_unused = ^bus.IR[14:0];

  // Instruction classes.  IR is stable from DECODE to the end of execute,
  // so these also steer the shared E0..E3 states.
  logic is_alu3, is_unary, is_muldiv, is_ld, is_st;
  assign is_alu3   = (opcode >= OP_ADD) && (opcode <= OP_SHL);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_ld     = (opcode == OP_LD);
  assign is_st     = (opcode == OP_ST);

  // One-hot ALU op, ordered {ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT,MUL,DIV}.
  logic [12:0] alu_sel;
  always_comb begin
    alu_sel = 13'd0;
    case (opcode)
      OP_ADD:  alu_sel = 13'b1_0000_0000_0000;
      OP_SUB:  alu_sel = 13'b0_1000_0000_0000;
      OP_AND:  alu_sel = 13'b0_0100_0000_0000;
      OP_OR:   alu_sel = 13'b0_0010_0000_0000;
      OP_SHR:  alu_sel = 13'b0_0001_0000_0000;
      OP_SHRA: alu_sel = 13'b0_0000_1000_0000;
      OP_SHL:  alu_sel = 13'b0_0000_0100_0000;
      OP_ROR:  alu_sel = 13'b0_0000_0010_0000;
      OP_ROL:  alu_sel = 13'b0_0000_0001_0000;
      OP_NEG:  alu_sel = 13'b0_0000_0000_1000;
      OP_NOT:  alu_sel = 13'b0_0000_0000_0100;
      OP_MUL:  alu_sel = 13'b0_0000_0000_0010;
      OP_DIV:  alu_sel = 13'b0_0000_0000_0001;
      default: alu_sel = 13'd0;
    endcase
  end

  logic in_wait, timeout;
  assign in_wait = (state == S_FETCH2) ||
                   ((state == S_E1) && is_ld) ||
                   ((state == S_E2) && is_st);
  assign timeout = WAIT_EN && in_wait && !bus.Mem_done && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = S_HALT;
    end else begin
      case (state)
        S_FETCH0: state_nx = bus.Stop ? S_HALT : S_FETCH1;
        S_FETCH1: state_nx = S_FETCH2;
        S_FETCH2: state_nx = bus.Mem_done ? S_FETCH3 : S_FETCH2;
        S_FETCH3: state_nx = S_DECODE;
        S_DECODE: begin
          if (bus.Stop)
            state_nx = S_HALT;
          else if (is_alu3 || is_unary || is_muldiv || is_ld || is_st)
            state_nx = S_E0;
          else if (opcode == OP_HALT)
            state_nx = S_HALT;
          else
            state_nx = S_FETCH0;  // unlisted opcode executes as a nop
        end
        S_E0: state_nx = S_E1;
        S_E1: begin
          if (is_unary)   state_nx = S_FETCH0;
          else if (is_ld) state_nx = bus.Mem_done ? S_E2 : S_E1;
          else            state_nx = S_E2;
        end
        S_E2: begin
          if (is_muldiv)  state_nx = S_E3;
          else if (is_st) state_nx = bus.Mem_done ? S_FETCH0 : S_E2;
          else            state_nx = S_FETCH0;
        end
        S_E3:    state_nx = S_FETCH0;
        S_HALT:  state_nx = S_HALT;
        default: state_nx = S_FETCH0;
      endcase
    end
  end

  // The wait counter idles at zero outside wait states.  It is therefore 0
  // on the first cycle of every wait, because no wait state directly
  // follows another.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= S_FETCH0;
      wait_cnt <= 32'd0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= in_wait ? wait_cnt + 32'd1 : 32'd0;
      if (timeout)
        fault <= 1'b1;
    end
  end

  // Ungated strobe decode.
  logic pc_out, zlow_out, zhigh_out, mdr_out;
  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, lo_in, hi_in;
  logic inc_pc, read, ram_read, ram_write, alu_on;
  logic [15:0] rin_v, rout_v;

  always_comb begin
    pc_out = 1'b0; zlow_out = 1'b0; zhigh_out = 1'b0; mdr_out = 1'b0;
    pc_in = 1'b0; ir_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; lo_in = 1'b0; hi_in = 1'b0;
    inc_pc = 1'b0; read = 1'b0; ram_read = 1'b0; ram_write = 1'b0;
    alu_on = 1'b0; rin_v = 16'd0; rout_v = 16'd0;
    case (state)
      S_FETCH0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
      S_FETCH1: begin zlow_out = 1'b1; pc_in = 1'b1; ram_read = 1'b1; end
      S_FETCH2: begin
        ram_read = 1'b1;
        read     = bus.Mem_done;
        mdr_in   = bus.Mem_done;
      end
      S_FETCH3: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_E0: begin
        if (is_alu3) begin
          rout_v = 16'd1 << rb; y_in = 1'b1;
        end else if (is_unary) begin
          rout_v = 16'd1 << rb; alu_on = 1'b1; z_in = 1'b1;
        end else if (is_muldiv) begin
          rout_v = 16'd1 << ra; y_in = 1'b1;
        end else if (is_ld || is_st) begin
          rout_v = 16'd1 << rb; mar_in = 1'b1;
        end
      end
      S_E1: begin
        if (is_alu3) begin
          rout_v = 16'd1 << rc; alu_on = 1'b1; z_in = 1'b1;
        end else if (is_unary) begin
          zlow_out = 1'b1; rin_v = 16'd1 << ra;
        end else if (is_muldiv) begin
          rout_v = 16'd1 << rb; alu_on = 1'b1; z_in = 1'b1;
        end else if (is_ld) begin
          ram_read = 1'b1;
          read     = bus.Mem_done;
          mdr_in   = bus.Mem_done;
        end else if (is_st) begin
          rout_v = 16'd1 << ra; mdr_in = 1'b1;  // MDR loads from the bus
        end
      end
      S_E2: begin
        if (is_alu3) begin
          zlow_out = 1'b1; rin_v = 16'd1 << ra;
        end else if (is_muldiv) begin
          zlow_out = 1'b1; lo_in = 1'b1;
        end else if (is_ld) begin
          mdr_out = 1'b1; rin_v = 16'd1 << ra;
        end else if (is_st) begin
          ram_write = 1'b1;
        end
      end
      S_E3: begin
        if (is_muldiv) begin
          zhigh_out = 1'b1; hi_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Everything is forced low while Clear is asserted and in HALT.
  logic active;
  assign active = Clear && (state != S_HALT);

  assign bus.PCout    = active & pc_out;
  assign bus.Zlowout  = active & zlow_out;
  assign bus.Zhighout = active & zhigh_out;
  assign bus.MDRout   = active & mdr_out;
  assign bus.LOout    = 1'b0;
  assign bus.HIout    = 1'b0;
  assign bus.PCin     = active & pc_in;
  assign bus.IRin     = active & ir_in;
  assign bus.MARin    = active & mar_in;
  assign bus.MDRin    = active & mdr_in;
  assign bus.Yin      = active & y_in;
  assign bus.Zin      = active & z_in;
  assign bus.LOin     = active & lo_in;
  assign bus.HIin     = active & hi_in;
  assign bus.IncPC    = active & inc_pc;
  assign bus.Read     = active & read;
  assign bus.RAMRead  = active & ram_read;
  assign bus.RAMWrite = active & ram_write;

  logic [12:0] alu_out;
  assign alu_out = (active && alu_on) ? alu_sel : 13'd0;
  assign {bus.ADD, bus.SUB, bus.AND, bus.OR, bus.SHR, bus.SHRA, bus.SHL,
          bus.ROR, bus.ROL, bus.NEG, bus.NOT, bus.MUL, bus.DIV} = alu_out;

  // R0 is hardwired zero: a load into it is dropped here.
  assign bus.Rin       = active ? (rin_v & 16'hFFFE) : 16'd0;
  assign bus.Rout      = active ? rout_v : 16'd0;
  assign bus.Run       = active;
  assign bus.Fault     = Clear & fault;
  assign bus.state_dbg = Clear ? state : S_FETCH0;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic Clock;
  logic Clear;
  logic Clear2;

  int tests_run    = 0;
  int tests_failed = 0;

  control_sequencer_if bus();
  control_sequencer_if bus2();

  control_sequencer #(.MEM_WAIT_MAX(0)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  control_sequencer #(.MEM_WAIT_MAX(4)) dut_to (
    .Clock (Clock),
    .Clear (Clear2),
    .bus   (bus2)
  );

  // Clock and reset.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Strobe bit positions, MSB first:
  // PCout Zlowout Zhighout MDRout LOout HIout PCin IRin MARin MDRin
  // Yin Zin LOin HIin IncPC Read RAMRead RAMWrite
  localparam logic [17:0] S_PCOUT    = 18'(1) << 17;
  localparam logic [17:0] S_ZLOWOUT  = 18'(1) << 16;
  localparam logic [17:0] S_ZHIGHOUT = 18'(1) << 15;
  localparam logic [17:0] S_MDROUT   = 18'(1) << 14;
  localparam logic [17:0] S_PCIN     = 18'(1) << 11;
  localparam logic [17:0] S_IRIN     = 18'(1) << 10;
  localparam logic [17:0] S_MARIN    = 18'(1) << 9;
  localparam logic [17:0] S_MDRIN    = 18'(1) << 8;
  localparam logic [17:0] S_YIN      = 18'(1) << 7;
  localparam logic [17:0] S_ZIN      = 18'(1) << 6;
  localparam logic [17:0] S_LOIN     = 18'(1) << 5;
  localparam logic [17:0] S_HIIN     = 18'(1) << 4;
  localparam logic [17:0] S_INCPC    = 18'(1) << 3;
  localparam logic [17:0] S_READ     = 18'(1) << 2;
  localparam logic [17:0] S_RAMREAD  = 18'(1) << 1;
  localparam logic [17:0] S_RAMWRITE = 18'(1) << 0;
  localparam logic [17:0] S_NONE     = 18'd0;

  // ALU order: ADD SUB AND OR SHR SHRA SHL ROR ROL NEG NOT MUL DIV
  localparam logic [12:0] A_ADD  = 13'(1) << 12;
  localparam logic [12:0] A_NEG  = 13'(1) << 3;
  localparam logic [12:0] A_MUL  = 13'(1) << 1;
  localparam logic [12:0] A_NONE = 13'd0;

  localparam logic [17:0] F0_S = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;

  wire [17:0] strobes = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.LOout,
                         bus.HIout, bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin,
                         bus.Zin, bus.LOin, bus.HIin, bus.IncPC, bus.Read, bus.RAMRead,
                         bus.RAMWrite};
  wire [12:0] alu = {bus.ADD, bus.SUB, bus.AND, bus.OR, bus.SHR, bus.SHRA, bus.SHL,
                     bus.ROR, bus.ROL, bus.NEG, bus.NOT, bus.MUL, bus.DIV};
  wire [17:0] strobes2 = {bus2.PCout, bus2.Zlowout, bus2.Zhighout, bus2.MDRout, bus2.LOout,
                          bus2.HIout, bus2.PCin, bus2.IRin, bus2.MARin, bus2.MDRin, bus2.Yin,
                          bus2.Zin, bus2.LOin, bus2.HIin, bus2.IncPC, bus2.Read, bus2.RAMRead,
                          bus2.RAMWrite};

  // Scoreboard check.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [17:0] s, input logic [12:0] a,
                            input logic [15:0] rin, input logic [15:0] rout, input logic run);
    check({tag, ".strobes"}, 32'(strobes), 32'(s));
    check({tag, ".alu"},     32'(alu),     32'(a));
    check({tag, ".rin"},     32'(bus.Rin), 32'(rin));
    check({tag, ".rout"},    32'(bus.Rout), 32'(rout));
    check({tag, ".run"},     32'(bus.Run), 32'(run));
  endtask

  // Driver tasks.
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Starts in FETCH0 with Mem_done=1 and ends one cycle into execute.
  task automatic run_fetch(input string tag);
    expect_out({tag, ".f0"}, F0_S, A_NONE, 16'd0, 16'd0, 1'b1);
    step();
    expect_out({tag, ".f1"}, S_ZLOWOUT | S_PCIN | S_RAMREAD, A_NONE, 16'd0, 16'd0, 1'b1);
    step();
    expect_out({tag, ".f2"}, S_RAMREAD | S_READ | S_MDRIN, A_NONE, 16'd0, 16'd0, 1'b1);
    step();
    expect_out({tag, ".f3"}, S_MDROUT | S_IRIN, A_NONE, 16'd0, 16'd0, 1'b1);
    step();
    expect_out({tag, ".dec"}, S_NONE, A_NONE, 16'd0, 16'd0, 1'b1);
    step();
  endtask

  task automatic report();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
  endtask

  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: got timeout expected completion");
    report();
    $finish;
  end

  initial begin
    int ram_cycles;
    Clear = 1'b0; Clear2 = 1'b0;
    bus.IR = 32'd0; bus.Mem_done = 1'b0; bus.Stop = 1'b0;
    bus2.IR = 32'd0; bus2.Mem_done = 1'b0; bus2.Stop = 1'b0;
    repeat (2) @(negedge Clock);
    expect_out("reset", S_NONE, A_NONE, 16'd0, 16'd0, 1'b0);
    check("reset.fault", 32'(bus.Fault), 32'd0);

    // add R1,R2,R3
    bus.IR = 32'h18918000; bus.Mem_done = 1'b1; Clear = 1'b1; #1;
    run_fetch("add");
    expect_out("add.e0", S_YIN, A_NONE, 16'd0, 16'h0004, 1'b1); step();
    expect_out("add.e1", S_ZIN, A_ADD, 16'd0, 16'h0008, 1'b1); step();
    expect_out("add.e2", S_ZLOWOUT, A_NONE, 16'h0002, 16'd0, 1'b1); step();

    // ld R4,(R5) with three stalled wait cycles
    bus.IR = 32'h02280000; #1;
    run_fetch("ld");
    expect_out("ld.e0", S_MARIN, A_NONE, 16'd0, 16'h0020, 1'b1);
    bus.Mem_done = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("ld.wait%0d", i), S_RAMREAD, A_NONE, 16'd0, 16'd0, 1'b1);
      step();
    end
    bus.Mem_done = 1'b1; #1;
    expect_out("ld.done", S_RAMREAD | S_READ | S_MDRIN, A_NONE, 16'd0, 16'd0, 1'b1); step();
    expect_out("ld.e2", S_MDROUT, A_NONE, 16'h0010, 16'd0, 1'b1); step();

    // mul R6,R7
    bus.IR = 32'h7B380000; #1;
    run_fetch("mul");
    expect_out("mul.e0", S_YIN, A_NONE, 16'd0, 16'h0040, 1'b1); step();
    expect_out("mul.e1", S_ZIN, A_MUL, 16'd0, 16'h0080, 1'b1); step();
    expect_out("mul.e2", S_ZLOWOUT | S_LOIN, A_NONE, 16'd0, 16'd0, 1'b1); step();
    expect_out("mul.e3", S_ZHIGHOUT | S_HIIN, A_NONE, 16'd0, 16'd0, 1'b1); step();

    // neg R3,R4
    bus.IR = 32'h89A00000; #1;
    run_fetch("neg");
    expect_out("neg.e0", S_ZIN, A_NEG, 16'd0, 16'h0010, 1'b1); step();
    expect_out("neg.e1", S_ZLOWOUT, A_NONE, 16'h0008, 16'd0, 1'b1); step();

    // st R2,(R6): Mem_done low in E1 is irrelevant, two stalled write cycles
    bus.IR = 32'h11300000; #1;
    run_fetch("st");
    expect_out("st.e0", S_MARIN, A_NONE, 16'd0, 16'h0040, 1'b1);
    bus.Mem_done = 1'b0; step();
    expect_out("st.e1", S_MDRIN, A_NONE, 16'd0, 16'h0004, 1'b1); step();
    for (int i = 0; i < 2; i++) begin
      expect_out($sformatf("st.wait%0d", i), S_RAMWRITE, A_NONE, 16'd0, 16'd0, 1'b1);
      step();
    end
    bus.Mem_done = 1'b1; #1;
    expect_out("st.done", S_RAMWRITE, A_NONE, 16'd0, 16'd0, 1'b1); step();

    // add R0,R2,R3: write to R0 dropped
    bus.IR = 32'h18118000; #1;
    run_fetch("addr0");
    expect_out("addr0.e0", S_YIN, A_NONE, 16'd0, 16'h0004, 1'b1); step();
    expect_out("addr0.e1", S_ZIN, A_ADD, 16'd0, 16'h0008, 1'b1); step();
    expect_out("addr0.e2", S_ZLOWOUT, A_NONE, 16'd0, 16'd0, 1'b1); step();

    // unlisted opcode: nop straight back to FETCH0
    bus.IR = 32'h60000000; #1;
    run_fetch("nop");

    // Clear mid-E1 of an add
    bus.IR = 32'h18918000; #1;
    run_fetch("clr");
    step();
    expect_out("clr.e1", S_ZIN, A_ADD, 16'd0, 16'h0008, 1'b1);
    Clear = 1'b0; #1;
    expect_out("clr.low", S_NONE, A_NONE, 16'd0, 16'd0, 1'b0);
    @(negedge Clock);
    Clear = 1'b1; #1;
    expect_out("clr.rel", F0_S, A_NONE, 16'd0, 16'd0, 1'b1);

    // Stop sampled in FETCH0
    bus.Stop = 1'b1; #1;
    expect_out("stop.f0", F0_S, A_NONE, 16'd0, 16'd0, 1'b1); step();
    bus.Stop = 1'b0;
    expect_out("stop.halt", S_NONE, A_NONE, 16'd0, 16'd0, 1'b0); step();
    expect_out("stop.hold", S_NONE, A_NONE, 16'd0, 16'd0, 1'b0);
    Clear = 1'b0; @(negedge Clock); Clear = 1'b1; #1;

    // halt instruction
    bus.IR = 32'hD8000000; #1;
    run_fetch("halt");
    expect_out("halt.h0", S_NONE, A_NONE, 16'd0, 16'd0, 1'b0); step();
    expect_out("halt.h1", S_NONE, A_NONE, 16'd0, 16'd0, 1'b0);
    check("halt.fault", 32'(bus.Fault), 32'd0);

    // Timeout instance: Mem_done stuck low in FETCH2
    Clear2 = 1'b1; #1;
    check("to.fault0", 32'(bus2.Fault), 32'd0);
    ram_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus2.RAMRead) ram_cycles++;
      step();
    end
    check("to.ramread_cycles", 32'(ram_cycles), 32'd5);
    check("to.fault", 32'(bus2.Fault), 32'd1);
    check("to.run", 32'(bus2.Run), 32'd0);
    check("to.strobes", 32'(strobes2), 32'd0);
    Clear2 = 1'b0; #1;
    check("to.fault_clr", 32'(bus2.Fault), 32'd0);

    report();
    $finish;
  end

endmodule
